// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes and requester count for alu_arbiter.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - core combinational ALU; flags compare the operands, zero reflects the result.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [3:0]  ctrl,
  output logic [31:0] result,
  output logic        lt,
  output logic        ltu,
  output logic        zero
);

  logic [4:0] shamt;

  assign shamt = op2[4:0];
  assign lt    = $signed(op1) < $signed(op2);
  assign ltu   = op1 < op2;

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD:  result = op1 + op2;
      ALU_SUB:  result = op1 - op2;
      ALU_AND:  result = op1 & op2;
      ALU_OR:   result = op1 | op2;
      ALU_XOR:  result = op1 ^ op2;
      ALU_SLL:  result = op1 << shamt;
      ALU_SRL:  result = op1 >> shamt;
      ALU_SRA:  result = $unsigned($signed(op1) >>> shamt);
      ALU_SLT:  result = {31'b0, lt};
      ALU_SLTU: result = {31'b0, ltu};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester front end sharing one ALU, with a registered response slot each.
// Round-robin by default; ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_op1,
  input  logic [31:0]      req0_op2,
  input  logic [3:0]       req0_ctrl,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_op1,
  input  logic [31:0]      req1_op2,
  input  logic [3:0]       req1_ctrl,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_result,
  output logic             rsp0_lt,
  output logic             rsp0_ltu,
  output logic             rsp0_zero,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_result,
  output logic             rsp1_lt,
  output logic             rsp1_ltu,
  output logic             rsp1_zero,
  output logic [TAG_W-1:0] rsp1_tag
);

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [31:0]        alu_op1;
  logic [31:0]        alu_op2;
  logic [3:0]         alu_ctrl;
  logic [TAG_W-1:0]   sel_tag;
  logic [31:0]        alu_result;
  logic               alu_lt;
  logic               alu_ltu;
  logic               alu_zero;

  // A slot that is being drained this cycle can take a new result on the same edge.
  assign elig[0] = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig[1] = req1_valid & (~rsp1_valid | rsp1_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant[0] = rst_n & elig[0];
  assign grant[1] = rst_n & elig[1] & ~elig[0];
`else
  // Index of the most recent winner; reset to 1 so requester 0 takes the first tie.
  logic last_grant;

  assign grant[0] = rst_n & elig[0] & (~elig[1] | last_grant);
  assign grant[1] = rst_n & elig[1] & (~elig[0] | ~last_grant);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (grant[0]) begin
      last_grant <= 1'b0;
    end else if (grant[1]) begin
      last_grant <= 1'b1;
    end
  end
`endif

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    alu_op1  = req0_op1;
    alu_op2  = req0_op2;
    alu_ctrl = req0_ctrl;
    sel_tag  = req0_tag;
    if (grant[1]) begin
      alu_op1  = req1_op1;
      alu_op2  = req1_op2;
      alu_ctrl = req1_ctrl;
      sel_tag  = req1_tag;
    end
  end

  alu u_alu (
    .op1    (alu_op1),
    .op2    (alu_op2),
    .ctrl   (alu_ctrl),
    .result (alu_result),
    .lt     (alu_lt),
    .ltu    (alu_ltu),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      if (grant[0]) begin
        rsp0_valid <= 1'b1;
      end else if (rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end
      if (grant[1]) begin
        rsp1_valid <= 1'b1;
      end else if (rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant[0]) begin
      rsp0_result <= alu_result;
      rsp0_lt     <= alu_lt;
      rsp0_ltu    <= alu_ltu;
      rsp0_zero   <= alu_zero;
      rsp0_tag    <= sel_tag;
    end
    if (grant[1]) begin
      rsp1_result <= alu_result;
      rsp1_lt     <= alu_lt;
      rsp1_ltu    <= alu_ltu;
      rsp1_zero   <= alu_zero;
      rsp1_tag    <= sel_tag;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter (honours ALU_ARB_FIXED_PRIO_EN).
module tb_alu_arbiter;

  localparam int TAG_W = 4;

  typedef struct {
    logic [31:0]      result;
    logic             lt;
    logic             ltu;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid  [2];
  logic [31:0]      op1        [2];
  logic [31:0]      op2        [2];
  logic [3:0]       ctrl       [2];
  logic [TAG_W-1:0] tag        [2];
  logic             rsp_ready  [2];
  logic             req_ready  [2];
  logic             rsp_valid  [2];
  logic [31:0]      rsp_result [2];
  logic             rsp_lt     [2];
  logic             rsp_ltu    [2];
  logic             rsp_zero   [2];
  logic [TAG_W-1:0] rsp_tag    [2];

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t mq [2][$];
  int   last_win = 1;
  int   acc_log [$];

  always #5 clk = ~clk;

  alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req_valid[0]),
    .req0_ready  (req_ready[0]),
    .req0_op1    (op1[0]),
    .req0_op2    (op2[0]),
    .req0_ctrl   (ctrl[0]),
    .req0_tag    (tag[0]),
    .req1_valid  (req_valid[1]),
    .req1_ready  (req_ready[1]),
    .req1_op1    (op1[1]),
    .req1_op2    (op2[1]),
    .req1_ctrl   (ctrl[1]),
    .req1_tag    (tag[1]),
    .rsp0_valid  (rsp_valid[0]),
    .rsp0_ready  (rsp_ready[0]),
    .rsp0_result (rsp_result[0]),
    .rsp0_lt     (rsp_lt[0]),
    .rsp0_ltu    (rsp_ltu[0]),
    .rsp0_zero   (rsp_zero[0]),
    .rsp0_tag    (rsp_tag[0]),
    .rsp1_valid  (rsp_valid[1]),
    .rsp1_ready  (rsp_ready[1]),
    .rsp1_result (rsp_result[1]),
    .rsp1_lt     (rsp_lt[1]),
    .rsp1_ltu    (rsp_ltu[1]),
    .rsp1_zero   (rsp_zero[1]),
    .rsp1_tag    (rsp_tag[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] c, input logic [TAG_W-1:0] t);
    rsp_t r;
    int   sh;
    sh = int'(b[4:0]);
    case (c)
      4'd0:    r.result = a + b;
      4'd1:    r.result = a - b;
      4'd2:    r.result = a & b;
      4'd3:    r.result = a | b;
      4'd4:    r.result = a ^ b;
      4'd5:    r.result = a << sh;
      4'd6:    r.result = a >> sh;
      4'd7:    r.result = $unsigned($signed(a) >>> sh);
      4'd8:    r.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    r.result = (a < b) ? 32'd1 : 32'd0;
      default: r.result = 32'd0;
    endcase
    r.lt   = $signed(a) < $signed(b);
    r.ltu  = a < b;
    r.zero = (r.result == 32'd0);
    r.tag  = t;
    return r;
  endfunction

  // Reference: who should be granted this cycle, what each slot must hold, then advance one edge.
  always @(negedge clk) begin
    bit e [2];
    bit g [2];
    for (int i = 0; i < 2; i++)
      e[i] = (rst_n === 1'b1) && (req_valid[i] === 1'b1) &&
             (mq[i].size() == 0 || rsp_ready[i] === 1'b1);
`ifdef ALU_ARB_FIXED_PRIO_EN
    g[0] = e[0];
    g[1] = e[1] && !e[0];
`else
    if (e[0] && e[1]) begin
      g[0] = (last_win == 1);
      g[1] = (last_win == 0);
    end else begin
      g[0] = e[0];
      g[1] = e[1];
    end
`endif
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("req%0d_ready", i), 32'(req_ready[i]), 32'(g[i]));
      chk($sformatf("rsp%0d_valid", i), 32'(rsp_valid[i]), 32'(mq[i].size() != 0));
      if (mq[i].size() != 0) begin
        chk($sformatf("rsp%0d_result", i), rsp_result[i], mq[i][0].result);
        chk($sformatf("rsp%0d_lt", i), 32'(rsp_lt[i]), 32'(mq[i][0].lt));
        chk($sformatf("rsp%0d_ltu", i), 32'(rsp_ltu[i]), 32'(mq[i][0].ltu));
        chk($sformatf("rsp%0d_zero", i), 32'(rsp_zero[i]), 32'(mq[i][0].zero));
        chk($sformatf("rsp%0d_tag", i), 32'(rsp_tag[i]), 32'(mq[i][0].tag));
      end
      if (req_valid[i] === 1'b1 && req_ready[i] === 1'b1) acc_log.push_back(i);
    end
    if (rst_n !== 1'b1) begin
      mq[0].delete();
      mq[1].delete();
      last_win = 1;
    end else begin
      for (int i = 0; i < 2; i++)
        if (mq[i].size() != 0 && rsp_ready[i] === 1'b1) void'(mq[i].pop_front());
      for (int i = 0; i < 2; i++)
        if (g[i]) begin
          mq[i].push_back(model(op1[i], op2[i], ctrl[i], tag[i]));
          last_win = i;
        end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] c, input logic [TAG_W-1:0] t);
    req_valid[i] = v;
    op1[i]       = a;
    op2[i]       = b;
    ctrl[i]      = c;
    tag[i]       = t;
  endtask

  initial begin
    int exp_grants [4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_grants = '{0, 0, 0, 0};
`else
    exp_grants = '{0, 1, 0, 1};
`endif
    rst_n = 1'b0;
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    drv(0, 1'b1, 32'd1, 32'd1, 4'd0, 4'd0);
    drv(1, 1'b1, 32'd2, 32'd2, 4'd0, 4'd0);
    smp();
    chk("reset_req0_ready", 32'(req_ready[0]), 32'd0);
    chk("reset_rsp0_valid", 32'(rsp_valid[0]), 32'd0);
    cyc();
    rst_n = 1'b1;
    drv(0, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    drv(1, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    smp();

    // single requester: 5 - 3
    cyc();
    drv(0, 1'b1, 32'd5, 32'd3, 4'b0001, 4'd2);
    smp();
    chk("single_ready", 32'(req_ready[0]), 32'd1);
    cyc();
    drv(0, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    smp();
    chk("single_valid", 32'(rsp_valid[0]), 32'd1);
    chk("single_result", rsp_result[0], 32'd2);
    chk("single_zero", 32'(rsp_zero[0]), 32'd0);
    chk("single_tag", 32'(rsp_tag[0]), 32'd2);

    // flags: SLT of -1 vs 1, then an undefined code
    cyc();
    drv(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b1000, 4'd3);
    smp();
    cyc();
    drv(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b1111, 4'd4);
    smp();
    chk("slt_result", rsp_result[1], 32'd1);
    chk("slt_lt", 32'(rsp_lt[1]), 32'd1);
    chk("slt_ltu", 32'(rsp_ltu[1]), 32'd0);
    cyc();
    drv(1, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    smp();
    chk("undef_result", rsp_result[1], 32'd0);
    chk("undef_zero", 32'(rsp_zero[1]), 32'd1);
    chk("undef_tag", 32'(rsp_tag[1]), 32'd4);

    // tie for four cycles
    acc_log.delete();
    for (int k = 0; k < 4; k++) begin
      cyc();
      drv(0, 1'b1, 32'(k), 32'd1, 4'd0, 4'(k));
      drv(1, 1'b1, 32'(10 * k), 32'd2, 4'd1, 4'(k + 8));
      smp();
    end
    cyc();
    drv(0, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    drv(1, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    smp();
    chk("tie_grant_count", 32'(acc_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < acc_log.size(); k++)
      chk($sformatf("tie_grant_%0d", k), 32'(acc_log[k]), 32'(exp_grants[k]));

    // backpressure on requester 1
    cyc();
    rsp_ready[1] = 1'b0;
    drv(1, 1'b1, 32'd10, 32'd20, 4'd0, 4'd5);
    smp();
    chk("bp_fill_ready", 32'(req_ready[1]), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      drv(0, 1'b1, 32'(k + 100), 32'd7, 4'(k + 2), 4'(k));
      drv(1, 1'b1, 32'd99, 32'd1, 4'd0, 4'd6);
      smp();
      chk("bp_req1_ready", 32'(req_ready[1]), 32'd0);
      chk("bp_req0_ready", 32'(req_ready[0]), 32'd1);
      chk("bp_rsp1_valid", 32'(rsp_valid[1]), 32'd1);
      chk("bp_rsp1_result", rsp_result[1], 32'd30);
      chk("bp_rsp1_tag", 32'(rsp_tag[1]), 32'd5);
    end
    cyc();
    rsp_ready[1] = 1'b1;
    drv(0, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    drv(1, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    smp();
    chk("bp_release_valid", 32'(rsp_valid[1]), 32'd1);
    cyc();
    smp();
    chk("bp_drained", 32'(rsp_valid[1]), 32'd0);

    // back-to-back drain/refill on requester 0
    for (int k = 0; k < 5; k++) begin
      cyc();
      drv(0, (k < 3), 32'(3 * k), 32'd1, 4'd0, 4'(k));
      smp();
      chk($sformatf("b2b_valid_%0d", k), 32'(rsp_valid[0]), 32'((k >= 1) && (k <= 3)));
      if (k < 3) chk($sformatf("b2b_ready_%0d", k), 32'(req_ready[0]), 32'd1);
    end

    // reset with both slots full
    cyc();
    rsp_ready[0] = 1'b0;
    rsp_ready[1] = 1'b0;
    drv(1, 1'b1, 32'd3, 32'd4, 4'd0, 4'd1);
    smp();
    cyc();
    drv(1, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    drv(0, 1'b1, 32'd8, 32'd8, 4'd1, 4'd2);
    smp();
    cyc();
    drv(0, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    smp();
    chk("full_rsp0_valid", 32'(rsp_valid[0]), 32'd1);
    chk("full_rsp1_valid", 32'(rsp_valid[1]), 32'd1);
    cyc();
    rst_n = 1'b0;
    smp();
    cyc();
    rst_n = 1'b1;
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    drv(0, 1'b1, 32'd1, 32'd2, 4'd0, 4'd7);
    drv(1, 1'b1, 32'd3, 32'd4, 4'd0, 4'd8);
    smp();
    chk("rst_rsp0_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp_valid[1]), 32'd0);
    chk("rst_tie_req0", 32'(req_ready[0]), 32'd1);
    chk("rst_tie_req1", 32'(req_ready[1]), 32'd0);
    cyc();
    drv(0, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    drv(1, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    smp();
    cyc();
    smp();
    cyc();
    smp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
